shift_issue_unit: RTL

//   Registered front/back end for the 32-bit mux-tree rotator (leftrightshift).

---
 rtl/shift_issue_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/shift_issue_unit.sv
// rtl/shift_issue_unit.sv - two-stage issue/mask wrapper around an external 32-bit rotator
`timescale 1ns/1ps
module shift_issue_unit #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [WIDTH-1:0] in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             rot_control,
    output logic [4:0]       rot_shift,
    output logic [WIDTH-1:0] rot_num,
    input  logic [WIDTH-1:0] rot_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_err,
    output logic             busy
);
    localparam logic [2:0] OP_ROL = 3'd0;
    localparam logic [2:0] OP_ROR = 3'd1;
    localparam logic [2:0] OP_SLL = 3'd2;
    localparam logic [2:0] OP_SRL = 3'd3;
    localparam logic [2:0] OP_SRA = 3'd4;

    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic [AMT_W-1:0] s1_amt_q, s1_amt_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_zero_q, out_zero_d;
    logic             out_err_q, out_err_d;

    logic             advance;
    logic             accept;
    logic             amt_big;
    logic [4:0]       amt_r;
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] res;
    logic             res_err;

    assign advance  = s1_valid_q & (~out_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | advance;
    assign accept   = in_valid & in_ready;

    assign rot_num     = s1_data_q;
    assign rot_shift   = s1_valid_q ? s1_amt_q[4:0] : 5'd0;
    assign rot_control = (s1_op_q == OP_ROR) | (s1_op_q == OP_SRL) | (s1_op_q == OP_SRA);

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_amt_d   = s1_amt_q;
        s1_data_d  = s1_data_q;
        s1_tag_d   = s1_tag_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = in_op;
            s1_amt_d   = in_amt;
            s1_data_d  = in_data;
            s1_tag_d   = in_tag;
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end
    end

    // Rotator output is post-masked; amounts of 32 or more saturate shifts.
    always_comb begin
        amt_big = |s1_amt_q[AMT_W-1:5];
        amt_r   = s1_amt_q[4:0];
        ones    = '1;
        res     = rot_out;
        res_err = 1'b0;
        case (s1_op_q)
            OP_ROL, OP_ROR: res = rot_out;
            OP_SLL: res = amt_big ? '0 : (rot_out & (ones << amt_r));
            OP_SRL: res = amt_big ? '0 : (rot_out & (ones >> amt_r));
            OP_SRA: begin
                if (amt_big)
                    res = {WIDTH{s1_data_q[WIDTH-1]}};
                else if (s1_data_q[WIDTH-1])
                    res = rot_out | ~(ones >> amt_r);
                else
                    res = rot_out & (ones >> amt_r);
            end
            default: begin
                res     = s1_data_q;
                res_err = 1'b1;
            end
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_zero_d  = out_zero_q;
        out_err_d   = out_err_q;
        if (advance) begin
            out_valid_d = 1'b1;
            out_data_d  = res;
            out_tag_d   = s1_tag_q;
            out_zero_d  = (res == '0);
            out_err_d   = res_err;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_amt_q    <= '0;
            s1_data_q   <= '0;
            s1_tag_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_zero_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_amt_q    <= s1_amt_d;
            s1_data_q   <= s1_data_d;
            s1_tag_q    <= s1_tag_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_zero_q  <= out_zero_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_zero  = out_zero_q;
    assign out_err   = out_err_q;
    assign busy      = s1_valid_q | out_valid_q;
endmodule
